encoder_position_tracker: RTL and testbench

- Consumes the per-clock direction code from the quadrature decoder stage (01 = CW step, 10 = CCW step, 00 = no step, 11 = illegal).
- Maintains a signed, wrapping position count.
- Produces a windowed velocity estimate: the net steps per fixed sample window.
- Flags illegal codes; sits between the decoder and the register/telemetry layer.

---
 rtl/enc_pkg.sv | 20 ++
 rtl/enc_window_timer.sv | 23 ++
 rtl/encoder_position_tracker.sv | 98 +++++++++
 tb/tb_encoder_position_tracker.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared step-code definitions for the quadrature decoder and position tracker.
package enc_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_CW   = 2'b01,
    DIR_CCW  = 2'b10,
    DIR_ERR  = 2'b11
  } dir_e;

  // Illegal codes contribute no motion; they are flagged separately.
  function automatic logic signed [1:0] dir_delta(input logic [1:0] dir);
    case (dir)
      DIR_CW:  return 2'sb01;
      DIR_CCW: return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/enc_window_timer.sv
// Free-running window counter; tc marks the last cycle of each velocity window.
module enc_window_timer #(
  parameter int unsigned WINDOW_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tc
);

  localparam int unsigned CW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/encoder_position_tracker.sv
// Wrapping position counter, saturating windowed velocity and error flag
// driven by the decoder's per-clock step code.
module encoder_position_tracker
  import enc_pkg::*;
#(
  parameter int unsigned POS_WIDTH     = 16,
  parameter int unsigned VEL_WIDTH     = 12,
  parameter int unsigned WINDOW_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           dir,
  input  logic                 clear,
  input  logic                 preset_en,
  input  logic [POS_WIDTH-1:0] preset_val,
  output logic [POS_WIDTH-1:0] position,
  output logic [VEL_WIDTH-1:0] velocity,
  output logic                 vel_valid,
  output logic                 wrap_pulse,
  output logic                 err_sticky
);

  localparam logic [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
  // Symmetric saturation limits, one bit wider than the accumulator.
  localparam logic signed [VEL_WIDTH:0] VMAX = {2'b00, {(VEL_WIDTH-1){1'b1}}};
  localparam logic signed [VEL_WIDTH:0] VMIN = {2'b11, {(VEL_WIDTH-2){1'b0}}, 1'b1};

  logic                        tc;
  logic signed [1:0]           delta;
  logic [POS_WIDTH-1:0]        pos_next;
  logic                        wrap_next;
  logic [VEL_WIDTH-1:0]        acc;
  logic signed [VEL_WIDTH:0]   acc_sum;
  logic [VEL_WIDTH-1:0]        acc_sat;

  enc_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tc   (tc)
  );

  assign delta = dir_delta(dir);

  always_comb begin
    pos_next  = position + {{(POS_WIDTH-2){delta[1]}}, delta};
    wrap_next = 1'b0;
    if (clear) begin
      pos_next = '0;
    end else if (preset_en) begin
      pos_next = preset_val;
    end else begin
      wrap_next = (dir == DIR_CW  && position == POS_MAX) ||
                  (dir == DIR_CCW && position == POS_MIN);
    end
  end

  always_comb begin
    acc_sum = $signed({acc[VEL_WIDTH-1], acc}) +
              $signed({{(VEL_WIDTH-1){delta[1]}}, delta});
    if (acc_sum > VMAX)      acc_sat = VMAX[VEL_WIDTH-1:0];
    else if (acc_sum < VMIN) acc_sat = VMIN[VEL_WIDTH-1:0];
    else                     acc_sat = acc_sum[VEL_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position   <= '0;
      wrap_pulse <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      position   <= pos_next;
      wrap_pulse <= wrap_next;
      if (clear)                err_sticky <= 1'b0;
      else if (dir == DIR_ERR)  err_sticky <= 1'b1;
    end
  end

  // The accumulator ignores clear/preset: velocity tracks physical motion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= tc;
      if (tc) begin
        velocity <= acc_sat;
        acc      <= '0;
      end else begin
        acc      <= acc_sat;
      end
    end
  end

endmodule

// File: tb/tb_encoder_position_tracker.sv
// Directed bench for encoder_position_tracker with a cycle-level reference model.
module tb_encoder_position_tracker;

  localparam int PW = 4;
  localparam int VW = 4;
  localparam int WC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    dir = 2'b00;
  logic          clear = 1'b0;
  logic          preset_en = 1'b0;
  logic [PW-1:0] preset_val = '0;
  logic [PW-1:0] position;
  logic [VW-1:0] velocity;
  logic          vel_valid;
  logic          wrap_pulse;
  logic          err_sticky;

  int n_cmp = 0;
  int n_err = 0;

  encoder_position_tracker #(
    .POS_WIDTH    (PW),
    .VEL_WIDTH    (VW),
    .WINDOW_CYCLES(WC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dir       (dir),
    .clear     (clear),
    .preset_en (preset_en),
    .preset_val(preset_val),
    .position  (position),
    .velocity  (velocity),
    .vel_valid (vel_valid),
    .wrap_pulse(wrap_pulse),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic.
  int m_pos, m_vel, m_acc, m_cnt;
  bit m_valid, m_wrap, m_err;

  always @(posedge clk or negedge rst_n) begin : model
    int d, np, s;
    if (!rst_n) begin
      m_pos <= 0; m_vel <= 0; m_acc <= 0; m_cnt <= 0;
      m_valid <= 0; m_wrap <= 0; m_err <= 0;
    end else begin
      d = (dir == 2'b01) ? 1 : (dir == 2'b10) ? -1 : 0;
      m_wrap <= 0;
      if (clear) m_pos <= 0;
      else if (preset_en) m_pos <= int'($signed(preset_val));
      else begin
        np = m_pos + d;
        if (np > 7)  begin np = np - 16; m_wrap <= 1; end
        if (np < -8) begin np = np + 16; m_wrap <= 1; end
        m_pos <= np;
      end
      if (clear) m_err <= 0;
      else if (dir == 2'b11) m_err <= 1;
      s = m_acc + d;
      if (s > 7)  s = 7;
      if (s < -7) s = -7;
      if (m_cnt == WC - 1) begin
        m_vel <= s; m_valid <= 1; m_acc <= 0; m_cnt <= 0;
      end else begin
        m_acc <= s; m_valid <= 0; m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if ($signed(position) != m_pos || $signed(velocity) != m_vel ||
        vel_valid != m_valid || wrap_pulse != m_wrap || err_sticky != m_err) begin
      n_err++;
      $display("FAIL model t=%0t pos=%0d/%0d vel=%0d/%0d vv=%0b/%0b wrap=%0b/%0b err=%0b/%0b (actual/required)",
               $time, $signed(position), m_pos, $signed(velocity), m_vel,
               vel_valid, m_valid, wrap_pulse, m_wrap, err_sticky, m_err);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; return after the next rising edge settles.
  task automatic cyc(input logic [1:0] d, input logic clr = 0,
                     input logic pre = 0, input logic [PW-1:0] pv = '0);
    dir = d; clear = clr; preset_en = pre; preset_val = pv;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_pos", int'($signed(position)), 0);
    chk("reset_vv", int'(vel_valid), 0);
    rst_n = 1'b1;

    // Window 1-2: idle
    for (int i = 1; i <= 16; i++) begin
      cyc(2'b00);
      if (i == 7) chk("idle_vv_c7", int'(vel_valid), 0);
      if (i == 8 || i == 16) begin
        chk("idle_vv", int'(vel_valid), 1);
        chk("idle_vel", int'($signed(velocity)), 0);
      end
    end
    chk("idle_pos", int'($signed(position)), 0);
    chk("idle_err", int'(err_sticky), 0);

    // Window 3: +5 -2
    repeat (5) cyc(2'b01);
    repeat (2) cyc(2'b10);
    chk("net_pos", int'($signed(position)), 3);
    cyc(2'b00);
    chk("net_vv", int'(vel_valid), 1);
    chk("net_vel", int'($signed(velocity)), 3);

    // Window 4: wrap both ways
    cyc(2'b00, 0, 1, 4'd7);
    chk("preset7_pos", int'($signed(position)), 7);
    chk("preset7_nowrap", int'(wrap_pulse), 0);
    cyc(2'b01);
    chk("wrap_up_pos", int'($signed(position)), -8);
    chk("wrap_up_pulse", int'(wrap_pulse), 1);
    cyc(2'b10);
    chk("wrap_dn_pos", int'($signed(position)), 7);
    chk("wrap_dn_pulse", int'(wrap_pulse), 1);
    cyc(2'b00);
    chk("wrap_clear", int'(wrap_pulse), 0);
    repeat (4) cyc(2'b00);

    // Windows 5-6: saturation
    repeat (8) cyc(2'b01);
    chk("sat_pos_vel", int'($signed(velocity)), 7);
    chk("sat_pos_vv", int'(vel_valid), 1);
    repeat (8) cyc(2'b10);
    chk("sat_neg_vel", int'($signed(velocity)), -7);

    // Window 7: error flag and clear
    cyc(2'b11);
    chk("err_pos", int'($signed(position)), 7);
    chk("err_set", int'(err_sticky), 1);
    cyc(2'b00);
    chk("err_hold", int'(err_sticky), 1);
    cyc(2'b00, 1);
    chk("clr_pos", int'($signed(position)), 0);
    chk("clr_err", int'(err_sticky), 0);
    cyc(2'b11, 1);
    chk("clr_vs_err", int'(err_sticky), 0);
    repeat (4) cyc(2'b00);

    // Window 8: preset drops delta for position but not for velocity
    cyc(2'b01, 0, 1, 4'd5);
    chk("preset5_pos", int'($signed(position)), 5);
    repeat (7) cyc(2'b00);
    chk("preset_vel", int'($signed(velocity)), 1);
    chk("preset_vv", int'(vel_valid), 1);

    // Reset mid-window
    repeat (3) cyc(2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pos", int'($signed(position)), 0);
    chk("mid_rst_vel", int'($signed(velocity)), 0);
    chk("mid_rst_err", int'(wrap_pulse | vel_valid | err_sticky), 0);
    dir = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= WC; k++) begin
      cyc(2'b00);
      chk($sformatf("post_rst_vv_%0d", k), int'(vel_valid), (k == WC) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
